// File: rtl/neopixel_pkg.sv
// Shared types, default WS2812 timing and the frame bit-order mapping
// for the NeoPixel output stage.
package neopixel_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_LATCH
  } state_t;

  localparam int unsigned DEF_NUM_PIXELS = 5;
  localparam int unsigned DEF_T0H        = 18;
  localparam int unsigned DEF_T0L        = 44;
  localparam int unsigned DEF_T1H        = 36;
  localparam int unsigned DEF_T1L        = 26;
  localparam int unsigned DEF_LATCH      = 2600;
  localparam int unsigned BITS_PER_PIXEL = 24;

  typedef struct packed {
    logic [2:0] pix;
    color_t     col;
    logic [2:0] bitn;
  } bit_loc_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Frame bit b -> pixel b/24, byte order G,R,B, each byte MSB first.
  function automatic bit_loc_t bit_loc(input int unsigned b);
    bit_loc_t    loc;
    int unsigned r;
    r        = b % BITS_PER_PIXEL;
    loc.pix  = 3'(b / BITS_PER_PIXEL);
    loc.bitn = 3'(7 - (r % 8));
    case (r / 8)
      32'd0:   loc.col = GREEN;
      32'd1:   loc.col = RED;
      default: loc.col = BLUE;
    endcase
    return loc;
  endfunction

endpackage

// File: rtl/neopixel_driver_counter.sv
// Up-counter with synchronous clear and load; holds at all-ones instead of wrapping.
module counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/neopixel_driver.sv
// WS2812 frame serializer: per-colour pixel buffer, one-wire bit timing,
// latch gap, and the load/send handshake toward the pattern generator.
module neopixel_driver
  import neopixel_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = DEF_NUM_PIXELS,
  parameter int unsigned T0H        = DEF_T0H,
  parameter int unsigned T0L        = DEF_T0L,
  parameter int unsigned T1H        = DEF_T1H,
  parameter int unsigned T1L        = DEF_T1L,
  parameter int unsigned LATCH      = DEF_LATCH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] pixel_index,
  input  logic [1:0] color_index,
  input  logic [7:0] color_level,
  input  logic       load_it,
  input  logic       send_it,
  output logic       neo_data,
  output logic       ready_to_load,
  output logic       ready_to_send
);

  localparam int unsigned NBITS = BITS_PER_PIXEL * NUM_PIXELS;
  localparam int unsigned BW    = $clog2(NBITS);
  localparam int unsigned TW    = $clog2(max3(T1H, T0L, LATCH));

  state_t          state_q, state_d;
  logic            neo_q;
  logic            rdy_q;
  logic [7:0]      buf_q [NUM_PIXELS][3];
  logic [BW-1:0]   bit_idx_q;
  logic [TW-1:0]   timer_q;
  logic            bit_en, bit_clr;
  logic            timer_en, timer_clr;
  logic            load_ok;
  logic            cur_bit;
  logic [TW-1:0]   hi_last, lo_last;
  bit_loc_t        loc;

  counter #(.WIDTH(BW)) u_bit_cnt (
    .clk_i    (clock),
    .rst_i    (reset),
    .en_i     (bit_en),
    .clr_i    (bit_clr),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .q_o      (bit_idx_q)
  );

  counter #(.WIDTH(TW)) u_timer (
    .clk_i    (clock),
    .rst_i    (reset),
    .en_i     (timer_en),
    .clr_i    (timer_clr),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .q_o      (timer_q)
  );

  always_comb begin
    loc     = bit_loc(32'(bit_idx_q));
    cur_bit = buf_q[loc.pix][loc.col][loc.bitn];
    hi_last = cur_bit ? TW'(T1H - 1) : TW'(T0H - 1);
    lo_last = cur_bit ? TW'(T1L - 1) : TW'(T0L - 1);
    load_ok = rdy_q && (state_q == S_IDLE) && load_it &&
              (32'(pixel_index) < NUM_PIXELS) && (color_index != 2'd3);
  end

  always_comb begin
    state_d = state_q;
    bit_en  = 1'b0;
    bit_clr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rdy_q && send_it) begin
          state_d = S_HIGH;
          bit_clr = 1'b1;
        end
      end
      S_HIGH: begin
        if (timer_q == hi_last) state_d = S_LOW;
      end
      S_LOW: begin
        if (timer_q == lo_last) begin
          if (bit_idx_q == BW'(NBITS - 1)) begin
            state_d = S_LATCH;
          end else begin
            state_d = S_HIGH;
            bit_en  = 1'b1;
          end
        end
      end
      S_LATCH: begin
        if (timer_q == TW'(LATCH - 1)) begin
          state_d = S_IDLE;
          bit_clr = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    timer_en  = (state_q != S_IDLE);
    timer_clr = (state_d != state_q);
  end

  // neo_data trails the state by one stage; ready returns one cycle after
  // IDLE re-entry, so the first-high to ready span is frame + LATCH exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      neo_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      neo_q   <= (state_q == S_HIGH);
      rdy_q   <= (state_q == S_IDLE) && (state_d == S_IDLE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PIXELS; p++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          buf_q[p][c] <= '0;
        end
      end
    end else if (load_ok) begin
      buf_q[pixel_index][color_index] <= color_level;
    end
  end

  assign neo_data      = neo_q;
  assign ready_to_load = rdy_q;
  assign ready_to_send = rdy_q;

endmodule

// File: tb/tb_neopixel_driver.sv
// Directed frame-level checks of neopixel_driver at default timing.
module tb_neopixel_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       load_it;
  logic       send_it;
  logic       neo_data;
  logic       ready_to_load;
  logic       ready_to_send;

  int n_cmp = 0;
  int n_err = 0;

  neopixel_driver dut (
    .clock         (clock),
    .reset         (reset),
    .pixel_index   (pixel_index),
    .color_index   (color_index),
    .color_level   (color_level),
    .load_it       (load_it),
    .send_it       (send_it),
    .neo_data      (neo_data),
    .ready_to_load (ready_to_load),
    .ready_to_send (ready_to_send)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic load(input logic [2:0] p, input logic [1:0] c, input logic [7:0] v);
    pixel_index = p;
    color_index = c;
    color_level = v;
    load_it     = 1'b1;
    @(negedge clock);
    load_it     = 1'b0;
  endtask

  // Entered on a negedge where neo_data is (or soon becomes) high; returns on
  // the first negedge where ready_to_send is seen high again.
  task automatic capture(input bit latch_send, output logic [119:0] bits,
                         output int bad, output int tail, output bit tmo);
    int h, l, g;
    bits = '0; bad = 0; tail = 0; tmo = 1'b0; g = 0;
    while (neo_data !== 1'b1 && g < 200) begin g++; @(negedge clock); end
    if (g >= 200) begin tmo = 1'b1; return; end
    for (int i = 0; i < 120; i++) begin
      h = 0; l = 0;
      while (neo_data === 1'b1 && h < 100) begin h++; @(negedge clock); end
      if (i < 119) begin
        while (neo_data === 1'b0 && l < 100) begin l++; @(negedge clock); end
      end else begin
        while (ready_to_send !== 1'b1 && l < 4000) begin
          send_it = latch_send && (l == 1000);
          l++;
          @(negedge clock);
        end
        send_it = 1'b0;
      end
      if (h >= 100 || (i < 119 && l >= 100) || l >= 4000) begin tmo = 1'b1; return; end
      if (h == 36) bits[i] = 1'b1;
      else if (h != 18) bad++;
      if (i < 119 && l != ((h == 36) ? 26 : 44)) bad++;
      if (i == 119) tail = l;
    end
  endtask

  task automatic run_frame(input string tag, input logic [119:0] exp, input int exp_tail,
                           input bit same_load, input logic [2:0] lp, input logic [1:0] lc,
                           input logic [7:0] lv, input bit mid_load, input bit latch_send);
    logic [119:0] bits;
    int bad, tail;
    bit tmo;
    send_it = 1'b1;
    if (same_load) begin
      pixel_index = lp; color_index = lc; color_level = lv; load_it = 1'b1;
    end
    @(negedge clock);
    send_it = 1'b0;
    load_it = 1'b0;
    chk({tag, "_lat0_neo"}, 128'(neo_data), 128'(1'b0));
    chk({tag, "_rdy_send_drop"}, 128'(ready_to_send), 128'(1'b0));
    chk({tag, "_rdy_load_drop"}, 128'(ready_to_load), 128'(1'b0));
    if (mid_load) begin
      pixel_index = 3'd0; color_index = 2'd0; color_level = 8'hFF; load_it = 1'b1;
    end
    @(negedge clock);
    load_it = 1'b0;
    chk({tag, "_lat1_neo"}, 128'(neo_data), 128'(1'b1));
    capture(latch_send, bits, bad, tail, tmo);
    chk({tag, "_timeout"}, 128'(tmo), 128'(1'b0));
    chk({tag, "_bits"}, 128'(bits), 128'(exp));
    chk({tag, "_bad_periods"}, 128'(bad), 128'(0));
    chk({tag, "_tail"}, 128'(tail), 128'(exp_tail));
    chk({tag, "_end_rdy_load"}, 128'(ready_to_load), 128'(1'b1));
    chk({tag, "_end_neo"}, 128'(neo_data), 128'(1'b0));
  endtask

  initial begin
    logic [119:0] e;
    int highs;
    reset = 1'b1; pixel_index = '0; color_index = '0; color_level = '0;
    load_it = 1'b0; send_it = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_neo", 128'(neo_data), 128'(1'b0));
    chk("reset_rdy_load", 128'(ready_to_load), 128'(1'b1));
    chk("reset_rdy_send", 128'(ready_to_send), 128'(1'b1));
    reset = 1'b0;
    @(negedge clock);

    // Empty buffer: 120 zero pulses, tail = T0L + LATCH.
    run_frame("empty", '0, 44 + 2600, 1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Pixel 0 red = FF -> frame bits 8..15.
    load(3'd0, 2'd0, 8'hFF);
    e = '0; e[15:8] = 8'hFF;
    run_frame("redff", e, 44 + 2600, 1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Same-edge load and send: pixel 4 blue = 01 -> only bit 119, tail T1L + LATCH.
    do_reset();
    e = '0; e[119] = 1'b1;
    run_frame("same", e, 26 + 2600, 1'b1, 3'd4, 2'd2, 8'h01, 1'b0, 1'b0);

    // Illegal loads, a load during HIGH and a send during LATCH all dropped.
    do_reset();
    load(3'd5, 2'd0, 8'hFF);
    load(3'd0, 2'd3, 8'hFF);
    run_frame("illegal", '0, 44 + 2600, 1'b0, '0, '0, '0, 1'b1, 1'b1);
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      if (neo_data === 1'b1) highs++;
      @(negedge clock);
    end
    chk("no_second_frame", 128'(highs), 128'(0));
    chk("no_second_frame_rdy", 128'(ready_to_send), 128'(1'b1));
    e = '0;
    run_frame("illegal_next", e, 44 + 2600, 1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Overwrite: pixel 2 green AA then 55; 0x55 MSB first on bits 48..55.
    do_reset();
    load(3'd2, 2'd1, 8'hAA);
    load(3'd2, 2'd1, 8'h55);
    e = '0; e[55:48] = 8'hAA;
    run_frame("overwrite", e, 44 + 2600, 1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Reset during the high phase of bit 30.
    do_reset();
    load(3'd0, 2'd1, 8'hFF);
    send_it = 1'b1;
    @(negedge clock);
    send_it = 1'b0;
    @(negedge clock);
    repeat (30 * 62 + 5) @(negedge clock);
    chk("mid_pre_neo", 128'(neo_data), 128'(1'b1));
    chk("mid_pre_rdy", 128'(ready_to_send), 128'(1'b0));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_reset_neo", 128'(neo_data), 128'(1'b0));
    chk("mid_reset_rdy_load", 128'(ready_to_load), 128'(1'b1));
    chk("mid_reset_rdy_send", 128'(ready_to_send), 128'(1'b1));
    run_frame("post_reset", '0, 44 + 2600, 1'b0, '0, '0, '0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neopixel_driver.md
# neopixel_driver

Downstream consumer of the pattern-generator stage.
- Accepts per-colour load requests into an internal pixel buffer.
- On a send request, serializes the whole buffer as a WS2812 (NeoPixel) one-wire frame on `neo_data`, followed by a latch/reset gap.
- Returns the `ready_to_load` / `ready_to_send` handshake that paces the generator.

## Interface
- `NUM_PIXELS`, 5: pixels in the strip and in the buffer (index width fixed at 3).
- `T0H`, 18: clock cycles `neo_data` is high for a 0 bit.
- `T0L`, 44: cycles low for a 0 bit.
- `T1H`, 36: cycles high for a 1 bit.
- `T1L`, 26: cycles low for a 1 bit.
- `LATCH`, 2600: cycles low after the last bit.
- Defaults give a 62-cycle bit period and a 52 µs latch at 50 MHz.

Ports:
- `clock`, in, 1: single clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `pixel_index`, in, 3: target pixel for a load.
- `color_index`, in, 2: 0 = red, 1 = green, 2 = blue, 3 = reserved.
- `color_level`, in, 8: intensity byte to store.
- `load_it`, in, 1: write request; sampled only while `ready_to_load` = 1.
- `send_it`, in, 1: frame request; sampled only while `ready_to_send` = 1.
- `neo_data`, out, 1: registered serial output to the strip.
- `ready_to_load`, out, 1: 1 only in IDLE.
- `ready_to_send`, out, 1: 1 only in IDLE.

## Operation
- **Buffer:** `NUM_PIXELS` × 3 bytes.
  - A load writes `color_level` into [`pixel_index`][`color_index`] at the clock edge.
  - The load is ignored if `pixel_index` ≥ `NUM_PIXELS`, if `color_index` = 3, or if the block is not in IDLE.
  - Repeated writes to the same slot: the last write wins.
- **States:** IDLE, HIGH, LOW, LATCH.
  - IDLE → HIGH on `send_it`. Bit index and timer are cleared.
  - HIGH → LOW after T0H or T1H cycles, chosen by the current bit.
  - LOW → HIGH at the next bit after T0L or T1L cycles.
  - LOW → LATCH after the final bit's low time.
  - LATCH → IDLE after `LATCH` cycles.
- **Bit order:**
  - Pixels are sent 0 first.
  - Within a pixel the byte order is green, red, blue.
  - Each byte is sent MSB first.
  - Total frame is 24·`NUM_PIXELS` bits (120 by default).
- **Output level:** `neo_data` = 1 only in HIGH, 0 in every other state.
- **Buffer lifetime:** contents persist across frames. Only reset clears them to 0.
- **Simultaneous `load_it` and `send_it` in IDLE:** the write commits at that edge, and the frame starts with the new value included.
- **Ignored requests:** `send_it` or `load_it` outside IDLE is dropped; nothing is queued.
- **Counter widths:** bit index width is $clog2(24·`NUM_PIXELS`). Timer width is $clog2 of the largest of T1H, T0L and `LATCH`. Both counters count up with no wrap, and are cleared on every state change.

## Timing
- **Reset values** (one cycle after `reset` is sampled high):
  - state IDLE, `neo_data` = 0, `ready_to_load` = 1, `ready_to_send` = 1.
  - buffer and counters all 0.
- **Send latency:** with `send_it` accepted at edge N, `neo_data` rises after edge N+1 (one registered stage).
- **Bit period:** exactly T0H+T0L or T1H+T1L cycles, with no extra gap cycles between bits.
- **Handshake timing:** the ready signals drop in the cycle after the accepting edge, and reassert on the first IDLE cycle after LATCH completes.
- **Frame length:** exactly 120×62 + `LATCH` cycles from the first high to the ready reassert (defaults, all bit periods 62).
- **Reset mid-frame:**
  - `neo_data` is 0 after the next edge.
  - state returns to IDLE and the buffer is cleared.
  - no partial latch is generated.

## Structure
- **Package `neopixel_pkg`:**
  - `color_t` enum (RED = 0, GREEN = 1, BLUE = 2).
  - `state_t` enum.
  - Default timing constants.
  - The byte-order function mapping bit index to (pixel, colour, bit).
- **Sub-module:** the existing `counter` (enable/clear/load, parameterized width) is instantiated twice, once as the bit index and once as the phase timer.

## Test plan
- **Reset, then send with an empty buffer:** expect 120 pulses, each high 18 / low 44, then 2600 cycles low, then both ready signals = 1.
- **Red = FF:** load pixel 0, colour 0, level 8'hFF, then send. Expect bits 0–7 as 0 pulses (18 high), bits 8–15 as 1 pulses (36 high), bits 16–119 as 0 pulses.
- **Same-cycle load and send:** pixel 4, blue, 8'h01. Expect bit 119 to be a 1 pulse and all other bits 0 pulses.
- **Illegal and mid-frame requests:**
  - `load_it` with `pixel_index` = 5, with `color_index` = 3, and during HIGH: none change the next frame.
  - `send_it` during LATCH produces no second frame.
- **Overwrite:** write pixel 2 green = 8'hAA, then 8'h55. Expect the next frame to carry 8'h55 at bits 48–55.
- **Reset mid-frame:** assert `reset` during bit 30. Expect `neo_data` = 0 the next cycle, ready signals = 1, and the following frame all zeros.
